bit_serializer: RTL and testbench

Parallel-to-serial front end that feeds the single-bit `x` input of the three-state sequence detector FSM. It accepts W-bit words over a valid/ready handshake and buffers one word ahead of the shifter. It emits one bit per `ck` cycle with no idle gap between back-to-back words. When no word is in flight it drives a fixed idle level, which parks the downstream detector in its reset-equivalent state.

---
 rtl/bit_serializer.sv | 103 ++++++++++
 tb/tb_bit_serializer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Word-to-bitstream front end for the sequence detector's x input.
// One word buffered ahead of the shifter; back-to-back words leave no gap.
module bit_serializer #(
  parameter int   W         = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic         ck,
  input  logic         r,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         x,
  output logic         busy,
  output logic         word_done
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CMAX = CW'(W-1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t         state, state_n;
  logic [W-1:0]   sreg, sreg_n;
  logic [W-1:0]   hold;
  logic [CW-1:0]  cnt, cnt_n;
  logic           hold_full, hold_full_n;
  logic           accept;

  assign din_ready = ~hold_full & ~r;
  assign accept    = din_valid & din_ready;
  assign busy      = (state == SHIFT) | hold_full;

  // state, shifter, counter and buffer flag; reset drops any word
  always_ff @(posedge ck) begin
    if (r) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      cnt       <= cnt_n;
      hold_full <= hold_full_n;
    end
  end

  // capture the offered word into the buffer on a handshake
  always_ff @(posedge ck) begin
    if (accept) begin
      hold <= din;
    end
  end

  // next-state, shift, drain of the buffer, and Moore outputs
  always_comb begin
    state_n     = state;
    sreg_n      = sreg;
    cnt_n       = cnt;
    hold_full_n = hold_full | accept;
    x           = IDLE_BIT;
    word_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (hold_full) begin
          sreg_n      = hold;
          cnt_n       = CMAX;
          hold_full_n = 1'b0;
          state_n     = SHIFT;
        end
      end
      SHIFT: begin
        if (MSB_FIRST) begin
          x      = sreg[W-1];
          sreg_n = {sreg[W-2:0], 1'b0};
        end else begin
          x      = sreg[0];
          sreg_n = {1'b0, sreg[W-1:1]};
        end
        cnt_n = cnt - 1'b1;
        if (cnt == '0) begin
          word_done = 1'b1;
          if (hold_full) begin
            sreg_n      = hold;
            cnt_n       = CMAX;
            hold_full_n = 1'b0;
          end else begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB- and LSB-first instances on shared stimulus,
// checked against a timeline model of accepted words.
module tb_bit_serializer;

  localparam int W = 8;

  logic         ck = 1'b0;
  logic         r = 1'b1;
  logic         din_valid = 1'b0;
  logic [W-1:0] din = '0;

  logic ready_m, x_m, busy_m, wd_m;
  logic ready_l, x_l, busy_l, wd_l;

  bit_serializer #(.W(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .ck(ck), .r(r), .din(din), .din_valid(din_valid),
    .din_ready(ready_m), .x(x_m), .busy(busy_m), .word_done(wd_m)
  );

  bit_serializer #(.W(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .ck(ck), .r(r), .din(din), .din_valid(din_valid),
    .din_ready(ready_l), .x(x_l), .busy(busy_l), .word_done(wd_l)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic [W-1:0] w;
    int           a;
    int           s;
  } wrd_t;

  wrd_t q[$];
  int   last_s = -1000;
  int   c = 0;
  int   ntests = 0;
  int   nfail = 0;
  int   nwd = 0;
  logic ex_m, ex_l, ewd, ebusy, erdy, eshift;
  logic [63:0] sm, sl;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, c, got, exp);
    end
  endtask

  task automatic model_eval();
    logic hold;
    hold   = 1'b0;
    eshift = 1'b0;
    ex_m   = 1'b0;
    ex_l   = 1'b0;
    ewd    = 1'b0;
    foreach (q[k]) begin
      if (c >= q[k].a && c <= q[k].s - 1) hold = 1'b1;
      if (c >= q[k].s && c <= q[k].s + W - 1) begin
        int i;
        i      = c - q[k].s;
        eshift = 1'b1;
        ex_m   = q[k].w[W-1-i];
        ex_l   = q[k].w[i];
        ewd    = (i == W - 1);
      end
    end
    ebusy = hold | eshift;
    erdy  = ~hold & ~r;
  endtask

  task automatic tick();
    logic acc;
    int   s;
    @(negedge ck);
    model_eval();
    chk("x_msb", x_m, ex_m);
    chk("x_lsb", x_l, ex_l);
    chk("busy_msb", busy_m, ebusy);
    chk("busy_lsb", busy_l, ebusy);
    chk("done_msb", wd_m, ewd);
    chk("done_lsb", wd_l, ewd);
    chk("ready_msb", ready_m, erdy);
    chk("ready_lsb", ready_l, erdy);
    if (eshift) begin
      sm = {sm[62:0], x_m};
      sl = {sl[62:0], x_l};
    end
    if (wd_m) nwd++;
    acc = din_valid & erdy;
    @(posedge ck);
    c++;
    if (r) begin
      q.delete();
      last_s = -1000;
    end else if (acc) begin
      s = (c + 1 > last_s + W) ? c + 1 : last_s + W;
      q.push_back('{din, c, s});
      last_s = s;
    end
    #1;
  endtask

  initial begin
    sm = '0;
    sl = '0;
    din_valid = 1'b1;
    din = 8'hAA;
    @(posedge ck);
    #1;
    tick();
    tick();
    r = 1'b0;
    din_valid = 1'b0;
    tick();

    // single word, both bit orders
    sm = '0; sl = '0;
    din = 8'hE5; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (10) tick();
    chk("e5_msb_stream", sm[7:0], 8'hE5);
    chk("e5_lsb_stream", sl[7:0], 8'hA7);

    sm = '0; sl = '0;
    din = 8'h01; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (10) tick();
    chk("01_lsb_stream", sl[7:0], 8'h80);
    chk("01_msb_stream", sm[7:0], 8'h01);

    // back-to-back with valid held
    sm = '0; sl = '0; nwd = 0;
    din = 8'hA5; din_valid = 1'b1;
    tick();
    din = 8'h3C;
    tick();
    tick();
    din_valid = 1'b0;
    repeat (18) tick();
    chk("b2b_stream", sm[15:0], 16'hA53C);
    chk("b2b_done_cnt", nwd, 2);

    // backpressure: din changes every cycle, valid held
    din_valid = 1'b1;
    repeat (40) begin
      din = W'($urandom);
      tick();
    end
    din_valid = 1'b0;
    repeat (12) tick();

    // random valid and data
    repeat (150) begin
      din_valid = 1'($urandom_range(0, 1));
      din = W'($urandom);
      tick();
    end
    din_valid = 1'b0;
    repeat (12) tick();

    // reset with one word shifting and one buffered
    nwd = 0;
    din = 8'hFF; din_valid = 1'b1;
    tick();
    din = 8'h0F;
    tick();
    tick();
    din_valid = 1'b0;
    tick();
    tick();
    r = 1'b1;
    tick();
    r = 1'b0;
    repeat (4) tick();
    chk("rst_no_done", nwd, 0);

    sm = '0; sl = '0;
    din = 8'h5A; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (10) tick();
    chk("post_rst_stream", sm[7:0], 8'h5A);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
